// File: rtl/readout_sequencer.sv
// Drift-chamber readout sequencer: gates the tubes for a drift window, then scans 32 channels into a FIFO.
// Optional build macro RO_SKIP_EMPTY_EN drops channels whose hit time is 8'h00 from the scan.
module readout_sequencer #(
    parameter int DRIFT_CYCLES = 256,
    parameter int CLR_CYCLES   = 11
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        trig,
    output logic        gate_en,
    output logic [4:0]  tube_sel,
    input  logic [7:0]  tube_data,
    output logic [15:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic        tube_clr,
    output logic        busy,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT, SCAN, TRAILER, CLEAR} state_t;

    localparam logic [15:0] WAIT_LAST  = 16'(DRIFT_CYCLES - 1);
    localparam logic [15:0] CLEAR_LAST = 16'(CLR_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        trig_q;
    logic        armed;
    logic        trig_rise;
    logic [15:0] cnt;
    logic [4:0]  ch;
    logic        advance;
    logic [7:0]  tube_name;

    // armed stays low after reset until trig has been seen low, so a stale latch cannot start an event
    assign trig_rise = trig & ~trig_q & armed;
    assign tube_name = {ch[2:0], ch[3], ch[4] ? 4'd4 : 4'd3};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            trig_q   <= 1'b0;
            armed    <= 1'b0;
            cnt      <= 16'd0;
            ch       <= 5'd0;
            drop_cnt <= 16'd0;
        end else begin
            state  <= next_state;
            trig_q <= trig;
            armed  <= armed | ~trig;
            if (state != next_state)
                cnt <= 16'd0;
            else if (state == WAIT || state == CLEAR)
                cnt <= cnt + 16'd1;
            if (advance)
                ch <= ch + 5'd1;
            if (trig_rise && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_comb begin
        next_state = state;
        gate_en    = 1'b0;
        tube_clr   = 1'b0;
        fifo_wr_en = 1'b0;
        tube_sel   = 5'd0;
        fifo_din   = 16'hFFFF;
        advance    = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (trig_rise)
                    next_state = WAIT;
            end
            WAIT: begin
                gate_en = 1'b1;
                if (cnt == WAIT_LAST)
                    next_state = SCAN;
            end
            SCAN: begin
                tube_sel = ch;
                fifo_din = {tube_data, tube_name};
`ifdef RO_SKIP_EMPTY_EN
                // Empty channels are skipped in a single cycle even when the FIFO is full
                if (tube_data == 8'h00) begin
                    advance = 1'b1;
                end else begin
                    fifo_wr_en = ~fifo_full;
                    advance    = ~fifo_full;
                end
`else
                fifo_wr_en = ~fifo_full;
                advance    = ~fifo_full;
`endif
                if (advance && ch == 5'd31)
                    next_state = TRAILER;
            end
            TRAILER: begin
                fifo_wr_en = ~fifo_full;
                if (!fifo_full)
                    next_state = CLEAR;
            end
            CLEAR: begin
                tube_clr = 1'b1;
                if (cnt == CLEAR_LAST)
                    next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: expected FIFO words are queued when a trigger is driven.
// Builds with or without RO_SKIP_EMPTY_EN; the expected word list follows the macro.
module tb_readout_sequencer;

    logic        clk;
    logic        clr;
    logic        trig;
    logic        gate_en;
    logic [4:0]  tube_sel;
    logic [7:0]  tube_data;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        tube_clr;
    logic        busy;
    logic [15:0] drop_cnt;

    logic [7:0]  tube_mem [32];
    logic [15:0] sb [$];
    int          checks = 0;
    int          errors = 0;

`ifdef RO_SKIP_EMPTY_EN
    localparam bit SKIP_EMPTY = 1'b1;
`else
    localparam bit SKIP_EMPTY = 1'b0;
`endif

    readout_sequencer #(.DRIFT_CYCLES(256), .CLR_CYCLES(11)) dut (
        .clk        (clk),
        .clr        (clr),
        .trig       (trig),
        .gate_en    (gate_en),
        .tube_sel   (tube_sel),
        .tube_data  (tube_data),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .tube_clr   (tube_clr),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    assign tube_data = tube_mem[tube_sel];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel naming: groups 3A,3B,4A,4B of eight tubes each
    function automatic logic [7:0] expected_name(input int ch);
        int grp = ch / 8;
        int idx = ch % 8;
        logic [2:0] i3 = idx[2:0];
        logic       ab = (grp == 1 || grp == 3);
        logic [3:0] ch_type = (grp >= 2) ? 4'd4 : 4'd3;
        return {i3, ab, ch_type};
    endfunction

    task automatic push_event(input int last_ch, input bit with_trailer);
        for (int ch = 0; ch <= last_ch; ch++)
            if (!(SKIP_EMPTY && tube_mem[ch] == 8'h00))
                sb.push_back({tube_mem[ch], expected_name(ch)});
        if (with_trailer)
            sb.push_back(16'hFFFF);
    endtask

    // Write monitor and exclusivity check, sampled mid-cycle
    always @(negedge clk) begin
        if (!clr) begin
            check_output("exclusive_strobes", 32'(gate_en) + 32'(tube_clr) + 32'(fifo_wr_en) <= 1, 1);
            if (fifo_wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("[TB] FAIL unexpected_write: observed=%0h expected=no write", fifo_din);
                end else begin
                    checks--;
                    check_output("fifo_word", fifo_din, sb.pop_front());
                end
            end
        end
    end

    // Drives one event from trig rise to IDLE; mode 1 adds three drops, mode 2 a drop on the exit edge
    task automatic apply_stimulus(input int mode, input int stall_ch,
                                  output int len, output int g, output int c);
        bit stalling = 0;
        int stall_left = 0;
        len = 0; g = 0; c = 0;
        trig = 1'b1;
        do begin
            @(posedge clk); #1;
            len++;
            if (gate_en) g++;
            if (tube_clr) c++;
            if (stalling) begin
                check_output("stall_tube_sel", tube_sel, 5'(stall_ch));
                check_output("stall_no_write", fifo_wr_en, 0);
                stall_left--;
                if (stall_left == 0) begin
                    fifo_full = 1'b0;
                    stalling  = 0;
                    stall_ch  = -1;
                end
            end else if (stall_ch >= 0 && busy && !gate_en && !tube_clr && tube_sel == 5'(stall_ch)) begin
                fifo_full  = 1'b1;
                stalling   = 1;
                stall_left = 7;
            end
            if (mode == 1) begin
                case (len)
                    10, 270, 295: trig = 1'b0;
                    11, 271, 296: trig = 1'b1;
                    default: ;
                endcase
            end else if (mode == 2) begin
                case (len)
                    299: trig = 1'b0;
                    300: trig = 1'b1;
                    default: ;
                endcase
            end
        end while (busy && len < 2000);
        trig = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int len, g, c, n;
        clr = 1'b1;
        trig = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < 32; i++) tube_mem[i] = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_gate_en", gate_en, 0);
        check_output("rst_tube_clr", tube_clr, 0);
        check_output("rst_wr_en", fifo_wr_en, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_tube_sel", tube_sel, 0);
        check_output("rst_fifo_din", fifo_din, 16'hFFFF);
        check_output("rst_drop_cnt", drop_cnt, 0);
        clr = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic event");
        push_event(31, 1);
        apply_stimulus(0, -1, len, g, c);
        check_output("basic_len", len, 301);
        check_output("basic_gate_cycles", g, 256);
        check_output("basic_clr_cycles", c, 11);
        check_output("basic_sb_empty", sb.size(), 0);

        $display("[TB] stall at ch 12");
        push_event(31, 1);
        apply_stimulus(0, 12, len, g, c);
        check_output("stall_len", len, 308);
        check_output("stall_gate_cycles", g, 256);
        check_output("stall_sb_empty", sb.size(), 0);

        $display("[TB] drops during WAIT/SCAN/CLEAR");
        push_event(31, 1);
        apply_stimulus(1, -1, len, g, c);
        check_output("drop_len", len, 301);
        check_output("drop_cnt_3", drop_cnt, 3);
        check_output("drop_sb_empty", sb.size(), 0);

        $display("[TB] drop on exit edge");
        push_event(31, 1);
        apply_stimulus(2, -1, len, g, c);
        check_output("exit_len", len, 301);
        check_output("drop_cnt_4", drop_cnt, 4);
        check_output("no_event_on_exit_edge", busy, 0);

        $display("[TB] drop saturation");
        force dut.drop_cnt = 16'hFFFE;
        #1;
        release dut.drop_cnt;
        push_event(31, 1);
        apply_stimulus(1, -1, len, g, c);
        check_output("drop_cnt_sat", drop_cnt, 16'hFFFF);

        $display("[TB] reset during SCAN");
        push_event(19, 0);
        trig = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(busy && !gate_en && tube_sel == 5'd20) && n < 1000);
        check_output("reached_ch20", tube_sel, 20);
        clr = 1'b1;
        #1;
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_gate_en", gate_en, 0);
        check_output("mid_rst_wr_en", fifo_wr_en, 0);
        check_output("mid_rst_tube_clr", tube_clr, 0);
        check_output("mid_rst_tube_sel", tube_sel, 0);
        check_output("mid_rst_fifo_din", fifo_din, 16'hFFFF);
        check_output("mid_rst_drop_cnt", drop_cnt, 0);
        check_output("mid_rst_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        clr = 1'b0;
        g = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy) g++;
        end
        check_output("held_trig_no_event", g, 0);
        trig = 1'b0;
        @(posedge clk); #1;
        push_event(31, 1);
        apply_stimulus(0, -1, len, g, c);
        check_output("rearm_len", len, 301);

        $display("[TB] empty channels");
        for (int i = 0; i < 32; i++) tube_mem[i] = 8'h00;
        tube_mem[0]  = 8'h10;
        tube_mem[31] = 8'h20;
        push_event(31, 1);
        check_output("sparse_expected_words", sb.size(), SKIP_EMPTY ? 3 : 33);
        apply_stimulus(0, -1, len, g, c);
        check_output("sparse_len", len, 301);
        check_output("sparse_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
